// File: rtl/mac_rx_arbiter.sv
// rtl/mac_rx_arbiter.sv - packet-granular round-robin merge of MAC rx streams
// Per-input FIFOs feed a one-packet-per-grant arbiter with registered outputs.
module mac_rx_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_QUEUES      = 4,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [NUM_QUEUES-1:0]            grant_pulse,
  output logic [NUM_QUEUES-1:0]            overflow,
  input  logic                             overflow_clr
);

  localparam int D  = 1 << FIFO_DEPTH_BITS;
  localparam int CW = FIFO_DEPTH_BITS + 1;
  localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic [CW-1:0]              FULL    = CW'(D);
  localparam logic [CW-1:0]              RDY_MAX = CW'(D - 2);
  localparam logic [CW-1:0]              CNT_ONE = CW'(1);
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE = FIFO_DEPTH_BITS'(1);
  localparam logic [QW-1:0]              Q_ONE   = QW'(1);
  localparam logic [QW-1:0]              Q_LAST  = QW'(NUM_QUEUES - 1);

  logic [DATA_WIDTH-1:0]      mem_data [NUM_QUEUES][D];
  logic [CTRL_WIDTH-1:0]      mem_ctrl [NUM_QUEUES][D];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr   [NUM_QUEUES];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr   [NUM_QUEUES];
  logic [CW-1:0]              count    [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]      seen;
  logic [NUM_QUEUES-1:0]      wr_ok;
  logic [NUM_QUEUES-1:0]      rd_en;

  logic [0:0]            state;
  logic [QW-1:0]         cur;
  logic [QW-1:0]         rr_ptr;
  logic [QW-1:0]         sel;
  logic                  found;
  int                    arb_idx;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  deq;
  logic                  eop;

  assign head_data = mem_data[cur][rd_ptr[cur]];
  assign head_ctrl = mem_ctrl[cur][rd_ptr[cur]];
  assign deq       = (state == XFER) && out_rdy && (count[cur] != '0);
  // A ctrl word only closes a packet once payload has been seen in this FIFO.
  assign eop       = (head_ctrl != '0) && seen[cur];

  always_comb begin
    in_rdy = '0;
    wr_ok  = '0;
    rd_en  = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      in_rdy[i] = (count[i] <= RDY_MAX);
      wr_ok[i]  = in_wr[i] && (count[i] != FULL);
      rd_en[i]  = deq && (cur == QW'(i));
    end
  end

  always_comb begin
    found   = 1'b0;
    sel     = '0;
    arb_idx = 0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      arb_idx = int'(rr_ptr) + k;
      if (arb_idx >= NUM_QUEUES) arb_idx = arb_idx - NUM_QUEUES;
      if (!found && (count[arb_idx] != '0)) begin
        found = 1'b1;
        sel   = QW'(arb_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (wr_ok[i]) begin
        mem_data[i][wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        mem_ctrl[i][wr_ptr[i]] <= in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      seen     <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (wr_ok[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (rd_en[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
          // Payload sets the flag; header words and EOP both leave it clear.
          seen[i]   <= (head_ctrl == '0);
        end
        case ({wr_ok[i], rd_en[i]})
          2'b10:   count[i] <= count[i] + CNT_ONE;
          2'b01:   count[i] <= count[i] - CNT_ONE;
          default: count[i] <= count[i];
        endcase
        if (in_wr[i] && (count[i] == FULL)) overflow[i] <= 1'b1;
        else if (overflow_clr)              overflow[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur         <= '0;
      rr_ptr      <= '0;
      grant_pulse <= '0;
      out_wr      <= 1'b0;
      out_data    <= '0;
      out_ctrl    <= '0;
    end else begin
      grant_pulse <= '0;
      out_wr      <= deq;
      if (deq) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
      end
      case (state)
        IDLE: begin
          if (found) begin
            cur              <= sel;
            grant_pulse[sel] <= 1'b1;
            state            <= XFER;
          end
        end
        default: begin
          if (deq && eop) begin
            rr_ptr <= (cur == Q_LAST) ? '0 : cur + Q_ONE;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mac_rx_arbiter.md
Name: mac_rx_arbiter

Overview:
- Packet-granular round-robin arbiter that merges the rx datapath outputs of NUM_QUEUES MAC groups into one user datapath stream.
- Sits between the per-port MAC group rx outputs (out_data/out_ctrl/out_wr/out_rdy) and the first user pipeline stage.
- Buffers each input in a small FIFO. Never interleaves words of different packets.
- Exports a per-grant pulse and an overflow flag for the register block.

Parameters:
- DATA_WIDTH, 64, datapath word width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width (one bit per byte).
- NUM_QUEUES, 4, number of MAC rx inputs, 2..8.
- FIFO_DEPTH_BITS, 3, log2 of per-input FIFO depth (depth D = 8).

Ports:
- clk  in  1  core clock, all logic rising-edge.
- reset  in  1  asynchronous active-low reset.
- in_data  in  NUM_QUEUES*DATA_WIDTH  input words, queue i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  input ctrl, same packing.
- in_wr  in  NUM_QUEUES  per-queue word write strobe.
- in_rdy  out  NUM_QUEUES  per-queue ready.
- out_data  out  DATA_WIDTH  merged output word.
- out_ctrl  out  CTRL_WIDTH  merged output ctrl.
- out_wr  out  1  output word valid.
- out_rdy  in  1  downstream ready.
- grant_pulse  out  NUM_QUEUES  one-cycle pulse when queue i wins a packet grant.
- overflow  out  NUM_QUEUES  sticky: a write arrived while FIFO i was full.
- overflow_clr  in  1  clears all overflow bits, sync.

Behaviour:
- Reset (reset=0, async): FIFOs empty; count=0; in_rdy all 1; out_wr=0; out_data/out_ctrl=0; grant_pulse=0; overflow=0; state=IDLE; rr pointer=0.
- FIFO i:
  - in_rdy[i] = (count_i <= D-2), driven from the registered count. One extra word after in_rdy falls is always accepted.
  - A write at count_i == D is dropped and sets overflow[i].
  - A simultaneous write and read keeps count_i unchanged.
  - A simultaneous overflow_clr and new overflow event: set wins.
- Packet framing:
  - EOP = word with ctrl != 0 whose predecessor in the same FIFO had ctrl == 0.
  - Leading header words (ctrl != 0 before any ctrl == 0 word) are never EOP.
  - Each FIFO keeps a 1-bit "seen payload" flag, written on dequeue and cleared after EOP.
- FSM:
  - IDLE: pick the first non-empty queue starting at rr pointer, wrapping NUM_QUEUES-1 -> 0.
    - If one is found: latch it as cur, pulse grant_pulse[cur] for 1 cycle, go to XFER.
    - If none: stay in IDLE.
  - XFER: each cycle where out_rdy=1 and FIFO cur is non-empty:
    - Dequeue one word.
    - Register it to out_data/out_ctrl with out_wr=1 on the next cycle; otherwise out_wr=0 (latency 1).
    - If the dequeued word is EOP: set rr pointer = cur+1 (wrap) and go to IDLE.
  - A FIFO cur that empties mid-packet stalls XFER (bubble). The grant is never dropped.
  - out_rdy=0 in XFER: no dequeue; out_wr=0 next cycle.
- Fairness and throughput:
  - One packet per grant.
  - IDLE costs 1 cycle between packets. Back-to-back throughput is L words in L+1 cycles.
- Reset mid-packet discards all buffered words. The partial packet is not completed.
- No combinational path from in_* to out_*. out_rdy to dequeue is combinational.

Test Plan:
- Single queue 0, packet ctrl 0xFF,0x00,0x00,0x80, out_rdy=1 -> grant_pulse[0] once; same 4 words on out_wr in order, one cycle after each dequeue; FSM back to IDLE.
- Queues 0..3 each hold a 3-word packet at t0 -> output order q0,q1,q2,q3; no interleave; grant_pulse one-hot sequence 1,2,4,8.
- rr wrap: after q3 is served, packets pending on q3 and q1 -> q1 is granted before q3.
- out_rdy held 0 for 5 cycles mid-packet -> out_wr=0 throughout; no words lost; count_cur unchanged; transfer resumes on the same word.
- Fill queue 2 with out_rdy=0 and 9 writes ignoring in_rdy -> in_rdy[2]=0 at count 7; 8 words stored; 9th dropped; overflow[2]=1; overflow_clr -> 0.
- Assert reset during XFER of an 8-word packet -> out_wr=0 and in_rdy all 1 immediately (async); all FIFOs report empty after release.
